// File: rtl/demux16_deser.sv
// Serial-to-parallel receiver for the 16:1 channel multiplexer path.
// Steers each valid beat into its channel slot and publishes whole 16-bit frames.
module demux16_deser (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_bit,
    input  logic        in_valid,
    input  logic        sync,
    output logic [15:0] out,
    output logic        frame_valid,
    output logic [3:0]  sel,
    output logic        locked,
    output logic        sync_err
);

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_e;

    localparam logic [3:0] LAST_CH = 4'd15;

    state_e      state_q, state_d;
    logic [3:0]  sel_q, sel_d;
    logic [15:0] shadow_q, shadow_d;
    logic [15:0] out_q, out_d;
    logic        frame_valid_q, frame_valid_d;
    logic        sync_err_q, sync_err_d;

    // NOTE: every next-state signal gets a default before any branch, so no path
    // through this block leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        shadow_d      = shadow_q;
        out_d         = out_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;

        if (in_valid) begin
            unique case (state_q)
                HUNT: begin
                    // Unsynchronised beats are dropped until a frame start shows up.
                    if (sync) begin
                        shadow_d[0] = in_bit;
                        sel_d       = 4'd1;
                        state_d     = LOCK;
                    end
                end
                LOCK: begin
                    if (sync && (sel_q != 4'd0)) begin
                        // Early sync: abandon the partial frame and restart at channel 0.
                        sync_err_d  = 1'b1;
                        shadow_d[0] = in_bit;
                        sel_d       = 4'd1;
                    end else begin
                        shadow_d[sel_q] = in_bit;
                        sel_d           = sel_q + 4'd1;
                        if (sel_q == LAST_CH) begin
                            out_d         = {in_bit, shadow_q[14:0]};
                            frame_valid_d = 1'b1;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    // NOTE: the shadow slots are reset too; it is only 16 flops and keeps the
    // visible frame contents deterministic after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= HUNT;
            sel_q         <= 4'd0;
            shadow_q      <= 16'h0000;
            out_q         <= 16'h0000;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            shadow_q      <= shadow_d;
            out_q         <= out_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign out         = out_q;
    assign frame_valid = frame_valid_q;
    assign sel         = sel_q;
    assign locked      = (state_q == LOCK);
    assign sync_err    = sync_err_q;

endmodule

// File: doc/demux16_deser.md
# demux16_deser

Serial-to-parallel receive end for the 16:1 channel multiplexer path. It accepts one bit per valid beat, where beat *i* of a frame carries channel *i* (the bit the multiplexer emits with sel = *i*). It steers each bit into its channel slot and presents the completed 16-bit frame as a registered parallel word with a one-cycle strobe. It sits downstream of any serialiser that scans sel 0→15 and marks channel 0 with a sync flag.

## Interface
- No parameters; channel count fixed at 16, select width fixed at 4.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_bit  input  1  serial data bit for the current channel.
- in_valid  input  1  in_bit is valid this cycle; one beat = one channel.
- sync  input  1  qualifies a valid beat as channel 0 (frame start); ignored when in_valid=0.
- out  output  16  last completed frame; out[i] = bit received on channel i.
- frame_valid  output  1  one-cycle pulse: out updated this cycle.
- sel  output  4  channel index the next valid beat will be written to.
- locked  output  1  high in LOCK state.
- sync_err  output  1  one-cycle pulse: sync seen at sel≠0 while locked.

## Operation
- State machine: HUNT and LOCK.
  - HUNT: valid beats without sync are discarded. A valid beat with sync writes shadow[0]=in_bit, sets sel=1, and moves to LOCK.
  - LOCK: each valid beat writes shadow[sel]=in_bit and increments sel modulo 16.
- Frame completion, LOCK only: a valid beat at sel=15 writes shadow[15], and on the same edge:
  - out ← complete shadow including the new bit;
  - frame_valid ← 1;
  - sel wraps to 0.
- sync in LOCK at sel=0: normal frame start. sync is optional at frame boundaries; with no sync, LOCK continues free-running.
- sync in LOCK at sel≠0 (early sync):
  - sync_err pulses;
  - the partial frame is discarded and out is unchanged;
  - the beat is taken as channel 0: shadow[0]=in_bit, sel=1, state stays LOCK.
- in_valid=0: no state change. Gaps of any length within a frame are allowed.
- The shadow register is internal. Slots not yet written in the current frame keep stale values, but every slot is overwritten before the next transfer to out, because completion requires a write at sel=15 after sel 0..14.
- No path from HUNT to LOCK except a sync beat. LOCK is left only via rst.

## Timing
- Reset values (async, immediate on rst=1):
  - state=HUNT, sel=0, shadow=0;
  - out=16'h0000, frame_valid=0, locked=0, sync_err=0.
- All outputs are registered.
- Latency: out and frame_valid update on the same edge that samples the 16th beat. They are visible the cycle after that beat is presented.
- frame_valid is high for exactly one cycle per completed frame.
- out holds its value until the next completion.
- sync_err is high for exactly one cycle on the edge that samples the offending beat.
- Throughput: one beat per cycle. Back-to-back frames give frame_valid every 16 cycles.
- rst asserted mid-frame discards the partial frame. rst released: the first accepted beat must carry sync.

## Test plan
- Reset, then 16 consecutive valid beats with sync on beat 0, bit i = bit i of 16'hA5C3 → on the edge sampling beat 15: out=16'hA5C3, frame_valid pulses once, sel=0, locked=1.
- After reset, 20 valid beats with sync=0, all in_bit=1 → locked=0, sel=0, out=16'h0000, no frame_valid.
- Lock, then a frame of 16'h8001 with idle gaps of 1–3 cycles between beats → out=16'h8001 after beat 15 only, with a single frame_valid.
- Lock, complete frame 16'h1234, send beats 0–6 of a new frame, then sync on the next beat → sync_err pulses, out stays 16'h1234, sel=1. Completing 15 more beats of 16'hFFFF → out=16'hFFFF.
- Lock, send 9 beats, assert rst for 1 cycle → out=0, sel=0, locked=0. Then 16 beats with sync on the first, pattern 16'h00FF → out=16'h00FF.
- Three back-to-back frames 16'h1111, 16'h2222, 16'h3333, with sync only on the first → frame_valid at cycles 16, 32, 48 after the first beat, with matching out values and no sync_err.
